// File: rtl/memory_access_scheduler_pkg.sv
// Constants shared by the memory access scheduler: bank codes, the data word
// returned on an ack timeout, and the scheduler state encoding.
package memory_access_scheduler_pkg;

  localparam logic [3:0] BANK_ROM    = 4'd1;
  localparam logic [3:0] BANK_CART   = 4'd2;
  localparam logic [3:0] BANK_EEPROM = 4'd3;
  localparam logic [3:0] BANK_SD     = 4'd4;

  localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } sched_state_t;

endpackage

// File: rtl/memory_access_scheduler_priority_select.sv
// Two-tier lowest-index-wins selector: promoted targets beat plain targets,
// and the lowest index wins inside the chosen tier. Purely combinational.
module sched_priority_select #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] promoted,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] winner,
  output logic             valid
);

  logic [WIDTH-1:0] eligible;
  logic [WIDTH-1:0] tier;

  assign eligible = promoted & target;
  assign tier     = (|eligible) ? eligible : target;

  // Isolate the lowest set bit of the chosen tier.
  assign winner = tier & (~tier + WIDTH'(1));
  assign valid  = |target;

endmodule

// File: rtl/memory_access_scheduler.sv
// Shares one single-outstanding memory device between NUM_CONTROLLERS requesters,
// with starvation promotion. Optional ack timeout enabled by SCHED_ACK_TIMEOUT_EN.
module memory_access_scheduler
  import memory_access_scheduler_pkg::*;
#(
  parameter int         NUM_CONTROLLERS = 3,
  parameter int         ADDRESS_WIDTH   = 25,
  parameter logic [3:0] DEVICE_BANK     = BANK_ROM,
  parameter int         MAX_WAIT        = 8,
  parameter int         ACK_TIMEOUT     = 256
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic [NUM_CONTROLLERS-1:0]               i_request,
  input  logic [NUM_CONTROLLERS-1:0]               i_write,
  output logic [NUM_CONTROLLERS-1:0]               o_busy,
  output logic [NUM_CONTROLLERS-1:0]               o_ack,
  input  logic [4*NUM_CONTROLLERS-1:0]             i_bank,
  input  logic [ADDRESS_WIDTH*NUM_CONTROLLERS-1:0] i_address,
  input  logic [32*NUM_CONTROLLERS-1:0]            i_data,
  output logic [32*NUM_CONTROLLERS-1:0]            o_data,
  output logic                                     o_device_request,
  output logic                                     o_device_write,
  input  logic                                     i_device_busy,
  input  logic                                     i_device_ack,
  output logic [ADDRESS_WIDTH-1:0]                 o_device_address,
  input  logic [31:0]                              i_device_data,
  output logic [31:0]                              o_device_data,
  output logic                                     o_timeout_error
);

  localparam int         OW           = (NUM_CONTROLLERS > 1) ? $clog2(NUM_CONTROLLERS) : 1;
  localparam logic [7:0] WAIT_PROMOTE = 8'(MAX_WAIT);

  sched_state_t              state, state_next;
  logic [OW-1:0]             owner;
  logic [OW-1:0]             winner_idx;
  logic [NUM_CONTROLLERS-1:0] target, promoted, winner;
  logic                      winner_valid;
  logic                      accept;
  logic                      timeout_hit;
  logic                      done;
  logic [7:0]                wait_count [NUM_CONTROLLERS];

  always_comb begin
    target   = '0;
    promoted = '0;
    for (int i = 0; i < NUM_CONTROLLERS; i++) begin
      target[i]   = i_request[i] && (i_bank[4*i +: 4] == DEVICE_BANK);
      promoted[i] = wait_count[i] >= WAIT_PROMOTE;
    end
  end

  sched_priority_select #(.WIDTH(NUM_CONTROLLERS)) u_select (
    .promoted (promoted),
    .target   (target),
    .winner   (winner),
    .valid    (winner_valid)
  );

  always_comb begin
    winner_idx = '0;
    for (int i = NUM_CONTROLLERS - 1; i >= 0; i--) begin
      if (winner[i]) winner_idx = OW'(i);
    end
  end

  assign accept = (state == IDLE) && winner_valid && !i_device_busy;
  assign o_busy = target & ~(accept ? winner : '0);

`ifdef SCHED_ACK_TIMEOUT_EN
  logic [15:0] ack_timer;
  logic        timeout_error;

  assign timeout_hit     = (state == WAIT_ACK) && !i_device_ack &&
                           (ack_timer == 16'(ACK_TIMEOUT - 1));
  assign o_timeout_error = timeout_error;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ack_timer     <= '0;
      timeout_error <= 1'b0;
    end else begin
      ack_timer <= ((state == WAIT_ACK) && !done) ? ack_timer + 16'd1 : 16'd0;
      if (timeout_hit) timeout_error <= 1'b1;
    end
  end
`else
  assign timeout_hit     = 1'b0;
  assign o_timeout_error = 1'b0;
`endif

  assign done = (state == WAIT_ACK) && (i_device_ack || timeout_hit);

  // Device side is driven only in the accepting cycle, zero otherwise.
  always_comb begin
    o_device_request = accept;
    o_device_write   = 1'b0;
    o_device_address = '0;
    o_device_data    = '0;
    if (accept) begin
      o_device_write   = i_write[winner_idx];
      o_device_address = i_address[ADDRESS_WIDTH*winner_idx +: ADDRESS_WIDTH];
      o_device_data    = i_data[32*winner_idx +: 32];
    end
  end

  always_comb begin
    o_ack  = '0;
    o_data = '0;
    if (state == WAIT_ACK) begin
      o_ack[owner]           = i_device_ack || timeout_hit;
      o_data[32*owner +: 32] = timeout_hit ? TIMEOUT_DATA : i_device_data;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = WAIT_ACK;
      WAIT_ACK: if (done)   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_next;
      if (accept) owner <= winner_idx;
    end
  end

  // Refused targets age by one per cycle; acceptance or withdrawal clears.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CONTROLLERS; i++) wait_count[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CONTROLLERS; i++) begin
        if (!target[i] || (accept && winner[i])) wait_count[i] <= '0;
        else if (wait_count[i] != 8'hFF)         wait_count[i] <= wait_count[i] + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_scheduler.sv
// Self-checking bench for memory_access_scheduler: directed scenarios plus a
// randomized phase, compared every cycle against a transaction-level model.
module tb_memory_access_scheduler;

  localparam int NC = 3;
  localparam int AW = 25;
  localparam int MAXW = 8;
  localparam int ACKT = 256;
`ifdef SCHED_ACK_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              i_clk;
  logic              i_reset;
  logic [NC-1:0]     i_request, i_write, o_busy, o_ack;
  logic [4*NC-1:0]   i_bank;
  logic [AW*NC-1:0]  i_address;
  logic [32*NC-1:0]  i_data, o_data;
  logic              o_device_request, o_device_write, i_device_busy, i_device_ack;
  logic [AW-1:0]     o_device_address;
  logic [31:0]       i_device_data, o_device_data;
  logic              o_timeout_error;

  memory_access_scheduler dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_request        (i_request),
    .i_write          (i_write),
    .o_busy           (o_busy),
    .o_ack            (o_ack),
    .i_bank           (i_bank),
    .i_address        (i_address),
    .i_data           (i_data),
    .o_data           (o_data),
    .o_device_request (o_device_request),
    .o_device_write   (o_device_write),
    .i_device_busy    (i_device_busy),
    .i_device_ack     (i_device_ack),
    .o_device_address (o_device_address),
    .i_device_data    (i_device_data),
    .o_device_data    (o_device_data),
    .o_timeout_error  (o_timeout_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Stimulus as seen by each requester and by the device.
  logic [NC-1:0] s_req, s_wr;
  logic [3:0]    s_bank [NC];
  logic [AW-1:0] s_addr [NC];
  logic [31:0]   s_data [NC];
  logic          s_dbusy, s_dack;
  logic [31:0]   s_ddata;

  // Reference model: is a transaction outstanding, who owns it, how long each
  // requester has been refused, how long the device has been silent.
  bit            m_in_txn;
  int            m_owner;
  int            m_wait [NC];
  int            m_elapsed;
  bit            m_err;
  bit            m_accept, m_tmo;
  int            m_win;
  logic [NC-1:0] tgt;

  logic [NC-1:0]    e_busy, e_ack;
  logic [32*NC-1:0] e_rdata;
  logic             e_req, e_wr, e_err;
  logic [AW-1:0]    e_addr;
  logic [31:0]      e_wdata;

  int passed = 0;
  int total  = 0;

  task automatic checkVal(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clearStim();
    s_req = '0; s_wr = '0; s_dbusy = 1'b0; s_dack = 1'b0; s_ddata = '0;
    for (int i = 0; i < NC; i++) begin
      s_bank[i] = 4'd0; s_addr[i] = '0; s_data[i] = '0;
    end
  endtask

  task automatic applyStimulus();
    i_request = s_req;
    i_write   = s_wr;
    for (int i = 0; i < NC; i++) begin
      i_bank[4*i +: 4]     = s_bank[i];
      i_address[AW*i +: AW] = s_addr[i];
      i_data[32*i +: 32]   = s_data[i];
    end
    i_device_busy = s_dbusy;
    i_device_ack  = s_dack;
    i_device_data = s_ddata;
  endtask

  task automatic resetModel();
    m_in_txn = 1'b0; m_owner = 0; m_elapsed = 0; m_err = 1'b0;
    for (int i = 0; i < NC; i++) m_wait[i] = 0;
  endtask

  task automatic computeExpected();
    int pw;
    m_win = -1; pw = -1; m_accept = 1'b0; m_tmo = 1'b0;
    e_busy = '0; e_ack = '0; e_rdata = '0;
    e_req = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
    for (int i = 0; i < NC; i++) tgt[i] = s_req[i] && (s_bank[i] == 4'd1);
    if (!m_in_txn) begin
      for (int i = NC - 1; i >= 0; i--) begin
        if (tgt[i]) m_win = i;
        if (tgt[i] && m_wait[i] >= MAXW) pw = i;
      end
      if (pw >= 0) m_win = pw;
      m_accept = (m_win >= 0) && !s_dbusy;
      if (m_accept) begin
        e_req = 1'b1; e_wr = s_wr[m_win]; e_addr = s_addr[m_win]; e_wdata = s_data[m_win];
      end
    end else begin
      m_tmo = TMO_EN && !s_dack && (m_elapsed + 1 == ACKT);
      e_ack[m_owner] = s_dack || m_tmo;
      e_rdata[32*m_owner +: 32] = m_tmo ? 32'hFFFF_FFFF : s_ddata;
    end
    for (int i = 0; i < NC; i++) e_busy[i] = tgt[i] && !(m_accept && i == m_win);
    e_err = m_err;
  endtask

  task automatic updateModel();
    for (int i = 0; i < NC; i++) begin
      if (tgt[i] && !(m_accept && i == m_win)) m_wait[i] = (m_wait[i] < 255) ? m_wait[i] + 1 : 255;
      else m_wait[i] = 0;
    end
    if (m_accept) begin
      m_in_txn = 1'b1; m_owner = m_win; m_elapsed = 0;
    end else if (m_in_txn) begin
      if (s_dack || m_tmo) m_in_txn = 1'b0;
      else m_elapsed++;
      if (m_tmo) m_err = 1'b1;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_busy"},  o_busy, e_busy);
    checkVal({tag, "_ack"},   o_ack, e_ack);
    checkVal({tag, "_rdata"}, o_data, e_rdata);
    checkVal({tag, "_dreq"},  o_device_request, e_req);
    checkVal({tag, "_dwr"},   o_device_write, e_wr);
    checkVal({tag, "_daddr"}, o_device_address, e_addr);
    checkVal({tag, "_dwdata"}, o_device_data, e_wdata);
    checkVal({tag, "_err"},   o_timeout_error, e_err);
  endtask

  task automatic stepBegin(input string tag);
    applyStimulus();
    #3;
    computeExpected();
    checkOutput(tag);
  endtask

  task automatic stepEnd();
    @(posedge i_clk);
    updateModel();
    #1;
  endtask

  task automatic step(input string tag);
    stepBegin(tag);
    stepEnd();
  endtask

  task automatic doReset(input string tag);
    applyStimulus();
    i_reset = 1'b1;
    resetModel();
    #3;
    computeExpected();
    checkOutput(tag);
    clearStim();
    applyStimulus();
    @(negedge i_clk);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic randomizeCtrl(input int i, input logic [3:0] bank);
    s_req[i] = 1'b1; s_wr[i] = 1'($urandom); s_bank[i] = bank;
    s_addr[i] = AW'($urandom); s_data[i] = $urandom;
  endtask

  bit            prev_busy [NC];
  bit            waiting [NC];
  int            cyc;
  bit            found;

  initial begin
    clearStim();
    applyStimulus();
    i_reset = 1'b1;

    // Reset state, with a targeting requester held off by a busy device.
    s_req[1] = 1'b1; s_bank[1] = 4'd1; s_addr[1] = 25'h1ABCDE; s_dbusy = 1'b1;
    doReset("rst");

    // Ctrl0 and ctrl2 collide; ctrl0 wins, ctrl2 follows after the ack.
    randomizeCtrl(0, 4'd1);
    randomizeCtrl(2, 4'd1);
    stepBegin("t1_acc0");
    checkVal("t1_addr0", o_device_address, s_addr[0]);
    checkVal("t1_busy2", o_busy[2], 1'b1);
    stepEnd();
    s_req[0] = 1'b0;
    step("t1_wait");
    s_dack = 1'b1; s_ddata = $urandom;
    step("t1_ack0");
    s_dack = 1'b0;
    stepBegin("t1_acc2");
    checkVal("t1_addr2", o_device_address, s_addr[2]);
    stepEnd();
    s_req[2] = 1'b0; s_dack = 1'b1; s_ddata = $urandom;
    step("t1_ack2");
    clearStim();
    step("t1_idle");

    // Ctrl0 hammers the device; ctrl1 must be promoted after MAX_WAIT refusals.
    randomizeCtrl(0, 4'd1);
    randomizeCtrl(1, 4'd1);
    found = 1'b0; cyc = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      s_dack = m_in_txn; s_ddata = $urandom;
      stepBegin("t2");
      if (o_device_request && o_device_address == s_addr[1]) begin
        found = 1'b1; cyc = c;
      end
      stepEnd();
    end
    checkVal("t2_promoted", found, 1'b1);
    checkVal("t2_cycle", cyc, 8);
    s_req = '0; s_dack = 1'b1;
    step("t2_ack1");
    clearStim();
    step("t2_idle");

    // Ctrl1 targets another bank: never busy, no device request.
    randomizeCtrl(1, 4'd3);
    for (int c = 0; c < 4; c++) begin
      stepBegin("t3");
      checkVal("t3_busy1", o_busy[1], 1'b0);
      checkVal("t3_dreq", o_device_request, 1'b0);
      stepEnd();
    end
    clearStim();

    // Ctrl1 read of 0x0000123 answered with 0xCAFEBABE.
    s_req[1] = 1'b1; s_wr[1] = 1'b0; s_bank[1] = 4'd1; s_addr[1] = 25'h0000123;
    stepBegin("t4_acc");
    checkVal("t4_addr", o_device_address, 25'h0000123);
    stepEnd();
    s_dack = 1'b1; s_ddata = 32'hCAFEBABE;
    stepBegin("t4_ack");
    checkVal("t4_ack1", o_ack, 3'b010);
    checkVal("t4_data", o_data, {32'h0, 32'hCAFEBABE, 32'h0});
    stepEnd();
    clearStim();
    step("t4_idle");

    // Reset during WAIT_ACK, then a stale ack two cycles after release.
    randomizeCtrl(1, 4'd1);
    step("t5_acc");
    s_req = '0;
    step("t5_wait");
    clearStim();
    doReset("t5_rst");
    step("t5_quiet");
    s_dack = 1'b1; s_ddata = $urandom;
    stepBegin("t5_stale");
    checkVal("t5_no_ack", o_ack, 3'b000);
    stepEnd();
    clearStim();

    // Randomized traffic: requesters hold while busy and wait for their ack.
    for (int i = 0; i < NC; i++) begin
      prev_busy[i] = 1'b0; waiting[i] = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NC; i++) begin
        if (prev_busy[i]) begin
        end else if (waiting[i]) begin
          s_req[i] = 1'b0;
        end else begin
          randomizeCtrl(i, (($urandom % 4) == 0) ? 4'd3 : 4'd1);
          s_req[i] = ($urandom % 3) != 0;
        end
      end
      s_dbusy = ($urandom % 4) == 0;
      s_dack  = ($urandom % 3) == 0;
      s_ddata = $urandom;
      stepBegin("rnd");
      for (int i = 0; i < NC; i++) begin
        prev_busy[i] = e_busy[i];
        if (m_accept && m_win == i) waiting[i] = 1'b1;
        if (e_ack[i]) waiting[i] = 1'b0;
      end
      stepEnd();
    end
    clearStim();
    s_dack = 1'b1;
    step("rnd_drain");
    clearStim();
    step("rnd_idle");

`ifdef SCHED_ACK_TIMEOUT_EN
    // Device never answers: timeout ack on the 256th waiting cycle.
    randomizeCtrl(2, 4'd1);
    step("t6_acc");
    s_req = '0;
    found = 1'b0; cyc = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      stepBegin("t6_wait");
      cyc++;
      if (o_ack[2]) begin
        found = 1'b1;
        checkVal("t6_tmo_data", o_data[95:64], 32'hFFFF_FFFF);
      end
      stepEnd();
    end
    checkVal("t6_ack_cycle", cyc, ACKT);
    for (int c = 0; c < 3; c++) begin
      stepBegin("t6_sticky");
      checkVal("t6_err", o_timeout_error, 1'b1);
      stepEnd();
    end
    doReset("t6_rst");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/memory_access_scheduler.md
Name: memory_access_scheduler

Overview:
Shares one single-outstanding memory device (SDRAM, cart control or EEPROM port) between NUM_CONTROLLERS requesters using the common request/write/busy/ack/bank bus. Controller 0 is the latency-critical N64 PI port and wins by default. Per-controller wait counters promote starving requesters (PC USB, SD DMA) after MAX_WAIT cycles. Instantiated between the requester buses and the memory device.

Parameters:
NUM_CONTROLLERS, 3, number of requesters; index 0 is highest base priority.
ADDRESS_WIDTH, 25, device address width.
DEVICE_BANK, 4'd1, bank code this device answers to (BANK_ROM).
MAX_WAIT, 8, cycles a targeting controller may be refused before promotion (1..255).
ACK_TIMEOUT, 256, cycles to wait for device ack (timeout feature only).

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_request  in  NUM_CONTROLLERS  per-controller request
i_write  in  NUM_CONTROLLERS  per-controller write flag
o_busy  out  NUM_CONTROLLERS  request not accepted this cycle
o_ack  out  NUM_CONTROLLERS  completion strobe to owner
i_bank  in  4*NUM_CONTROLLERS  bank per controller, slice i at [4i+:4]
i_address  in  ADDRESS_WIDTH*NUM_CONTROLLERS  slice i at [AW*i+:AW]
i_data  in  32*NUM_CONTROLLERS  write data per controller
o_data  out  32*NUM_CONTROLLERS  read data per controller
o_device_request  out  1  request to device
o_device_write  out  1  write flag to device
i_device_busy  in  1  device cannot accept
i_device_ack  in  1  device completion (reads and writes)
o_device_address  out  ADDRESS_WIDTH  muxed address
i_device_data  in  32  device read data
o_device_data  out  32  muxed write data
o_timeout_error  out  1  sticky ack-timeout flag

Behaviour:
- Clock i_clk only; reset i_reset asynchronous, active-high.
- target[i] = i_request[i] && i_bank[i]==DEVICE_BANK. Non-targeting controllers see busy=0, ack=0.
- States: IDLE, WAIT_ACK.
- IDLE: winner = lowest index among promoted targets, else lowest index among all targets. Acceptance when a winner exists and !i_device_busy: same cycle (combinational) o_device_request=1, write/address/data muxed from winner; owner latched; next state WAIT_ACK.
- o_busy[i] = target[i] && !(IDLE && accept && i==winner). In WAIT_ACK every target sees busy.
- WAIT_ACK: o_ack[owner]=i_device_ack; o_data slice owner = i_device_data, other slices 0. On ack -> IDLE. No acceptance in the ack cycle; one bubble minimum between transactions.
- Ack seen in IDLE (stale) is dropped; no o_ack.
- Wait counter[i], 8-bit saturating: +1 each cycle target[i] && !accepted[i]; cleared on acceptance or when target[i] drops. promoted[i] = counter[i] >= MAX_WAIT.
- Requester must hold request/write/bank/address/data stable while busy; deassertion while busy simply withdraws it.
- Reset values: state IDLE, owner 0, counters 0, o_timeout_error 0; hence o_busy=target, o_ack=0, o_data=0, o_device_request=0, o_device_write=0, o_device_address=0, o_device_data=0.
- Reset mid-transaction aborts ownership; a later device ack is dropped as stale.

Optional Feature:
Macro SCHED_ACK_TIMEOUT_EN.
- Defined: 16-bit cycle counter runs in WAIT_ACK; on reaching ACK_TIMEOUT without ack, state returns to IDLE, o_ack[owner] pulses one cycle with o_data slice = 32'hFFFF_FFFF, and o_timeout_error sets (cleared only by reset).
- Undefined: no counter; WAIT_ACK waits indefinitely; o_timeout_error tied 0.

Decomposition:
- Shared constants package: bank codes (BANK_ROM, BANK_CART, BANK_EEPROM, BANK_SD), timeout data pattern 32'hFFFF_FFFF, state encoding.
- Sub-module sched_priority_select: combinational two-tier lowest-index-wins selector (promoted mask, target mask) -> one-hot winner plus valid.

Test Plan:
- Ctrl0 and ctrl2 request bank 1 in the same cycle, counters 0 -> ctrl0 accepted, busy[2]=1; after device ack, ctrl2 accepted on the next IDLE cycle.
- Ctrl0 requests continuously, ctrl1 held, MAX_WAIT=8 -> ctrl1 accepted after its counter reaches 8, ahead of ctrl0.
- Ctrl1 requests bank 3 with DEVICE_BANK=1 -> o_busy[1]=0, o_device_request never asserted.
- Ctrl1 reads address 0x0000123, device returns 0xCAFEBABE with ack -> o_ack[1]=1, o_data[63:32]=0xCAFEBABE, other slices 0.
- Reset asserted in WAIT_ACK, device acks 2 cycles after release -> no o_ack, state IDLE.
- SCHED_ACK_TIMEOUT_EN, ACK_TIMEOUT=256, device never acks -> o_ack[owner] at cycle 256 with 0xFFFFFFFF; o_timeout_error=1 until reset.
